// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Optional build macro used by muldiv_unit: MULDIV_FAST_MUL_EN.
package muldiv_pkg;

   localparam int MD_DATA_WIDTH    = 32;
   localparam int MD_OPCODE_LENGTH = 3;
   localparam int MD_CNT_W         = $clog2(MD_DATA_WIDTH);
   localparam logic [MD_DATA_WIDTH-1:0] MD_MOST_NEG = {1'b1, {(MD_DATA_WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } md_state_e;

   // rs1 is treated as signed for these operations
   function automatic logic md_a_signed(input md_op_e op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
             (op == MD_DIV) || (op == MD_REM);
   endfunction

   // rs2 is treated as signed for these operations
   function automatic logic md_b_signed(input md_op_e op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Turns the unsigned product/quotient/remainder into the final RV32M result:
// applies sign correction, picks hi/lo product half, and handles
// divide-by-zero and signed-overflow cases.
module muldiv_sign_fix
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
   input  logic [2*DATA_WIDTH-1:0] prod_i,
   input  logic [DATA_WIDTH-1:0]   quo_i,
   input  logic [DATA_WIDTH-1:0]   rem_i,
   input  logic [DATA_WIDTH-1:0]   dividend_i,
   input  logic                    neg_ab_i,
   input  logic                    neg_a_i,
   input  logic                    div0_i,
   input  logic                    ovf_i,
   input  md_op_e                  op_i,
   output logic [DATA_WIDTH-1:0]   result_o
);

   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [2*DATA_WIDTH-1:0] prod_fix;
   logic [DATA_WIDTH-1:0]   quo_fix;
   logic [DATA_WIDTH-1:0]   rem_fix;

   assign prod_fix = neg_ab_i ? -prod_i : prod_i;
   assign quo_fix  = neg_ab_i ? -quo_i  : quo_i;
   assign rem_fix  = neg_a_i  ? -rem_i  : rem_i;

   // Final result select per operation, special division cases first
   always_comb begin
      result_o = '0;
      case (op_i)
         MD_MUL:                        result_o = prod_fix[DATA_WIDTH-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU:  result_o = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
         MD_DIV, MD_DIVU: begin
            if (div0_i)     result_o = '1;
            else if (ovf_i) result_o = MOST_NEG;
            else            result_o = quo_fix;
         end
         MD_REM, MD_REMU: begin
            if (div0_i)     result_o = dividend_i;
            else if (ovf_i) result_o = '0;
            else            result_o = rem_fix;
         end
         default:           result_o = '0;
      endcase
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit for the EX stage.
// Operands are reduced to magnitudes at launch, iterated unsigned
// (shift-add multiply, restoring divide), then sign-fixed.
// Optional build macro: MULDIV_FAST_MUL_EN gives single-cycle multiplies.
//
// state | meaning
// IDLE  | waiting for Start
// CALC  | one multiply/divide iteration per cycle, counter 0..DATA_WIDTH-1
// FIX   | sign correction / half select, Result loaded on exit
// DONE  | Done pulse, Result valid
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH    = MD_DATA_WIDTH,
   parameter int OPCODE_LENGTH = MD_OPCODE_LENGTH
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     Start,
   input  logic                     Flush,
   input  logic [OPCODE_LENGTH-1:0] Operation,
   input  logic [DATA_WIDTH-1:0]    SrcA,
   input  logic [DATA_WIDTH-1:0]    SrcB,
   output logic                     Busy,
   output logic                     Done,
   output logic [DATA_WIDTH-1:0]    Result
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_WIDTH-1);
   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   md_state_e               state_q, state_d;
   md_op_e                  op_q, op_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
   logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, dvd_q, dvd_d, result_q, result_d;
   logic                    neg_ab_q, neg_ab_d, neg_a_q, neg_a_d;
   logic                    div0_q, div0_d, ovf_q, ovf_d;

   md_op_e                  launch_op;
   logic                    sign_a, sign_b;
   logic [DATA_WIDTH-1:0]   mag_a, mag_b;
   logic [DATA_WIDTH:0]     mul_sum, div_trial;
   logic [2*DATA_WIDTH-1:0] mul_step, div_step, prod_src;
   logic [DATA_WIDTH-1:0]   fix_result;

   assign launch_op = md_op_e'(Operation[2:0]);
   assign sign_a    = md_a_signed(launch_op) & SrcA[DATA_WIDTH-1];
   assign sign_b    = md_b_signed(launch_op) & SrcB[DATA_WIDTH-1];
   assign mag_a     = sign_a ? -SrcA : SrcA;
   assign mag_b     = sign_b ? -SrcB : SrcB;

   // Multiply: multiplier sits in the low half and is consumed LSB first
   assign mul_sum  = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} +
                     {1'b0, (acc_q[0] ? a_q : {DATA_WIDTH{1'b0}})};
   assign mul_step = {mul_sum, acc_q[DATA_WIDTH-1:1]};

   // Divide: {remainder, dividend/quotient}; trial is one bit wider so the
   // shifted remainder never overflows before the compare
   assign div_trial = {acc_q[2*DATA_WIDTH-1:DATA_WIDTH], acc_q[DATA_WIDTH-1]} - {1'b0, b_q};
   assign div_step  = div_trial[DATA_WIDTH] ?
                      {acc_q[2*DATA_WIDTH-2:0], 1'b0} :
                      {div_trial[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b1};

`ifdef MULDIV_FAST_MUL_EN
   logic [2*DATA_WIDTH-1:0] fast_prod;
   assign fast_prod = {{DATA_WIDTH{1'b0}}, a_q} * {{DATA_WIDTH{1'b0}}, b_q};
   assign prod_src  = op_q[2] ? acc_q : fast_prod;
`else
   assign prod_src  = acc_q;
`endif

   muldiv_sign_fix #(.DATA_WIDTH(DATA_WIDTH)) u_sign_fix (
      .prod_i     (prod_src),
      .quo_i      (acc_q[DATA_WIDTH-1:0]),
      .rem_i      (acc_q[2*DATA_WIDTH-1:DATA_WIDTH]),
      .dividend_i (dvd_q),
      .neg_ab_i   (neg_ab_q),
      .neg_a_i    (neg_a_q),
      .div0_i     (div0_q),
      .ovf_i      (ovf_q),
      .op_i       (op_q),
      .result_o   (fix_result)
   );

   // Next-state, operand capture and iteration datapath
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      a_d      = a_q;
      b_d      = b_q;
      dvd_d    = dvd_q;
      neg_ab_d = neg_ab_q;
      neg_a_d  = neg_a_q;
      div0_d   = div0_q;
      ovf_d    = ovf_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (Start && !Flush) begin
               op_d     = launch_op;
               a_d      = mag_a;
               b_d      = mag_b;
               dvd_d    = SrcA;
               neg_ab_d = sign_a ^ sign_b;
               neg_a_d  = sign_a;
               div0_d   = (SrcB == '0);
               ovf_d    = (launch_op == MD_DIV) && (SrcA == MOST_NEG) && (SrcB == '1);
               acc_d    = Operation[2] ? {{DATA_WIDTH{1'b0}}, mag_a} : {{DATA_WIDTH{1'b0}}, mag_b};
               cnt_d    = '0;
`ifdef MULDIV_FAST_MUL_EN
               state_d  = Operation[2] ? CALC : FIX;
`else
               state_d  = CALC;
`endif
            end
         end
         CALC: begin
            acc_d = op_q[2] ? div_step : mul_step;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = FIX;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         FIX: begin
            result_d = fix_result;
            state_d  = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (Flush && (state_q != IDLE)) begin
         state_d  = IDLE;
         cnt_d    = '0;
         result_d = result_q;
      end
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         op_q     <= MD_MUL;
         cnt_q    <= '0;
         acc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         dvd_q    <= '0;
         neg_ab_q <= 1'b0;
         neg_a_q  <= 1'b0;
         div0_q   <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         dvd_q    <= dvd_d;
         neg_ab_q <= neg_ab_d;
         neg_a_q  <= neg_a_d;
         div0_q   <= div0_d;
         ovf_q    <= ovf_d;
         result_q <= result_d;
      end
   end

   assign Busy   = (state_q != IDLE);
   assign Done   = (state_q == DONE);
   assign Result = result_q;

endmodule
